// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding for the pipeline sequencer.
// The datapath and display decode the sequencer state with these values.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    BREAK  = 2'd3
  } pipe_state_e;

  // States in which run/step requests are accepted.
  function automatic logic is_stopped(input pipe_state_e s);
    return (s == HALTED) || (s == BREAK);
  endfunction

endpackage

// File: rtl/pipe_tick_div.sv
// Free-running divider for the RUN rate: counts 0..TICK_DIV-1 while enabled.
// tc flags the last count; clr has priority over en.
module pipe_tick_div #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic Clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tc = (cnt_reg == LAST);

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Run/step/breakpoint sequencer producing a one-cycle pipeline advance enable.
// All outputs come straight from registers.
module pipe_seq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_if,
  output logic             pipe_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  pipe_state_e      state_reg, state_next;
  logic             pipe_en_reg, pipe_en_next;
  logic             bp_hit_reg, bp_hit_next;
  logic             skip_reg, skip_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             div_clr, div_en, div_tc;
  logic             bp_match;

  pipe_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .Clk (Clk),
    .rst (rst),
    .clr (div_clr),
    .en  (div_en),
    .tc  (div_tc)
  );

  // The skip flag lets a resume from BREAK execute the breakpointed PC once.
  assign bp_match = bp_en && (pc_if == bp_addr) && !skip_reg;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= HALTED;
      pipe_en_reg <= 1'b0;
      bp_hit_reg  <= 1'b0;
      skip_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pipe_en_reg <= pipe_en_next;
      bp_hit_reg  <= bp_hit_next;
      skip_reg    <= skip_next;
      cnt_reg     <= cnt_reg + CNT_W'(pipe_en_reg);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HALTED, BREAK: begin
        if (halt_req)      state_next = HALTED;
        else if (step_req) state_next = STEP;
        else if (run_req)  state_next = RUN;
      end
      STEP: state_next = HALTED;
      RUN: begin
        if (halt_req)                state_next = HALTED;
        else if (div_tc && bp_match) state_next = BREAK;
      end
      default: state_next = HALTED;
    endcase
  end

  always_comb begin
    pipe_en_next = 1'b0;
    bp_hit_next  = bp_hit_reg;
    skip_next    = skip_reg;
    div_clr      = 1'b0;
    div_en       = 1'b0;
    if (is_stopped(state_reg)) begin
      if (!halt_req) begin
        if (step_req) begin
          pipe_en_next = 1'b1;
          bp_hit_next  = 1'b0;
        end else if (run_req) begin
          div_clr     = 1'b1;
          skip_next   = (state_reg == BREAK);
          bp_hit_next = 1'b0;
        end
      end
    end else if (state_reg == RUN) begin
      if (halt_req) begin
        div_clr = 1'b1;
      end else begin
        div_en = 1'b1;
        if (div_tc) begin
          if (bp_match) begin
            bp_hit_next = 1'b1;
          end else begin
            pipe_en_next = 1'b1;
            skip_next    = 1'b0;
          end
        end
      end
    end
  end

  assign pipe_en   = pipe_en_reg;
  assign state     = state_reg;
  assign bp_hit    = bp_hit_reg;
  assign cycle_cnt = cnt_reg;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Randomized and directed bench for pipe_seq_ctrl against an edge-counting reference model.
module tb_pipe_seq_ctrl;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 8;

  logic             Clk;
  logic             rst;
  logic             run_req, step_req, halt_req;
  logic             bp_en;
  logic [31:0]      bp_addr, pc_if;
  logic             pipe_en;
  logic [1:0]       state;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, edges since RUN entry, expected outputs.
  int m_state, m_edges, m_cnt;
  bit m_pe, m_hit, m_skip;
  int dut_pulses;

  pipe_seq_ctrl #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk       (Clk),
    .rst       (rst),
    .run_req   (run_req),
    .step_req  (step_req),
    .halt_req  (halt_req),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc_if     (pc_if),
    .pipe_en   (pipe_en),
    .state     (state),
    .bp_hit    (bp_hit),
    .cycle_cnt (cycle_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_edges = 0; m_cnt = 0;
    m_pe = 0; m_hit = 0; m_skip = 0;
    pc_if = 32'h0;
  endtask

  // One rising edge of the spec's behaviour, using the inputs seen at that edge.
  task automatic model_edge();
    int nxt;
    bit pe_n;
    if (m_pe) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    pe_n = 0;
    nxt  = m_state;
    if (m_state == 0 || m_state == 3) begin
      if (halt_req) nxt = 0;
      else if (step_req) begin nxt = 2; pe_n = 1; m_hit = 0; end
      else if (run_req) begin nxt = 1; m_skip = (m_state == 3); m_hit = 0; m_edges = 0; end
    end else if (m_state == 2) begin
      nxt = 0;
    end else begin
      m_edges++;
      if (halt_req) nxt = 0;
      else if (m_edges % TICK_DIV == 0) begin
        if (bp_en && pc_if == bp_addr && !m_skip) begin nxt = 3; m_hit = 1; end
        else begin pe_n = 1; m_skip = 0; end
      end
    end
    m_state = nxt;
    m_pe    = pe_n;
  endtask

  task automatic do_cycle(input bit r, input bit s, input bit h);
    run_req = r; step_req = s; halt_req = h;
    if (r || s || h)
      $display("t=%0t req run=%0b step=%0b halt=%0b pc=%0h state=%0d cnt=%0d",
               $time, r, s, h, pc_if, state, cycle_cnt);
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    run_req = 0; step_req = 0; halt_req = 0;
    check("state", 32'(state), 32'(m_state));
    check("pipe_en", 32'(pipe_en), 32'(m_pe));
    check("bp_hit", 32'(bp_hit), 32'(m_hit));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    if (pipe_en) dut_pulses++;
    if (m_pe) pc_if = (pc_if + 32'd4) & 32'h3c;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pipe_en", 32'(pipe_en), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    model_reset();
    @(negedge Clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    run_req = 0; step_req = 0; halt_req = 0;
    bp_en = 0; bp_addr = 32'h0; pc_if = 32'h0;
    dut_pulses = 0;
    model_reset();
    apply_reset();

    // Idle after reset
    dut_pulses = 0;
    for (int i = 0; i < 20; i++) do_cycle(0, 0, 0);
    check("idle_pulses", 32'(dut_pulses), 32'd0);

    // Three spaced steps
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 1, 0);
      check("step_pulse", 32'(pipe_en), 32'd1);
      for (int i = 0; i < 4; i++) do_cycle(0, 0, 0);
    end
    check("step_cnt", 32'(cycle_cnt), 32'd3);

    // Continuous run then halt
    dut_pulses = 0;
    do_cycle(1, 0, 0);
    for (int i = 0; i < 17; i++) do_cycle(0, 0, 0);
    do_cycle(0, 0, 1);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 0);
    check("run_pulses", 32'(dut_pulses), 32'd4);
    check("run_halted", 32'(state), 32'd0);

    // Breakpoint at 0x10 then resume past it
    apply_reset();
    bp_en = 1; bp_addr = 32'h10;
    do_cycle(1, 0, 0);
    for (int i = 0; i < 40 && m_state != 3; i++) do_cycle(0, 0, 0);
    check("bp_state", 32'(state), 32'd3);
    check("bp_flag", 32'(bp_hit), 32'd1);
    check("bp_cnt", 32'(cycle_cnt), 32'd4);
    dut_pulses = 0;
    do_cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0);
    check("resume_pulse", 32'(dut_pulses), 32'd1);
    check("resume_bp_hit", 32'(bp_hit), 32'd0);
    do_cycle(0, 0, 1);
    bp_en = 0;

    // Coincident halt+step while HALTED and at RUN terminal count
    dut_pulses = 0;
    do_cycle(0, 1, 1);
    do_cycle(0, 0, 0);
    do_cycle(1, 0, 0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0);
    do_cycle(0, 1, 1);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 0);
    check("coincide_pulses", 32'(dut_pulses), 32'd0);
    check("coincide_state", 32'(state), 32'd0);

    // Counter wrap after 256 steps
    apply_reset();
    for (int k = 0; k < 255; k++) begin
      do_cycle(0, 1, 0);
      do_cycle(0, 0, 0);
    end
    check("cnt_255", 32'(cycle_cnt), 32'd255);
    do_cycle(0, 1, 0);
    do_cycle(0, 0, 0);
    check("cnt_wrap", 32'(cycle_cnt), 32'd0);

    // Asynchronous reset in the middle of a STEP cycle
    do_cycle(0, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async_pipe_en", 32'(pipe_en), 32'd0);
    check("async_state", 32'(state), 32'd0);
    model_reset();
    @(negedge Clk);
    rst = 1'b1;

    // Randomized requests and breakpoints
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 29) == 0) bp_addr = 32'($urandom_range(0, 15)) << 2;
      do_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Run/step/breakpoint sequencer for the five-stage pipeline. Replaces the free-running divided clock with a single-cycle enable, `pipe_en`, on the board clock `Clk`. Every pipeline register and the PC advance only when `pipe_en` is high. The block lets the board run continuously at a divided rate, single-step, halt, or stop on a PC breakpoint, and counts issued pipeline advances for the display.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: `Clk` cycles per pipeline advance in RUN. Legal range is ≥2.
- `CNT_W`, default 32: width of `cycle_cnt`.

Ports:
- `Clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `run_req` in 1: one-cycle pulse; start continuous run.
- `step_req` in 1: one-cycle pulse; advance the pipeline exactly once.
- `halt_req` in 1: one-cycle pulse; stop.
- `bp_en` in 1: breakpoint enable; level.
- `bp_addr` in 32: breakpoint PC; byte address.
- `pc_if` in 32: PC currently presented to fetch.
- `pipe_en` out 1: pipeline advance enable; registered; high for exactly one `Clk` cycle per advance.
- `state` out 2: current FSM state.
- `bp_hit` out 1: sticky breakpoint flag.
- `cycle_cnt` out `CNT_W`: number of completed `pipe_en` pulses; wraps modulo 2^`CNT_W`.

## Operation
- States and encodings: HALTED=0, RUN=1, STEP=2, BREAK=3.
- Reset values: state HALTED, `pipe_en` 0, `bp_hit` 0, `cycle_cnt` 0, divider 0, skip flag 0.
- Request priority when pulses coincide: `halt_req` > `step_req` > `run_req`. A lower-priority request in the same cycle is dropped.
- HALTED or BREAK:
  - `run_req` → RUN. Divider cleared to 0. Skip flag set only when leaving BREAK. `bp_hit` cleared.
  - `step_req` → STEP. `bp_hit` cleared.
  - `halt_req` → HALTED.
- STEP: `pipe_en`=1 for this one cycle, then → HALTED unconditionally. Requests arriving during STEP are ignored. The breakpoint is never checked in STEP.
- RUN behaviour:
  - The divider counts 0..`TICK_DIV`-1 and wraps to 0.
  - At terminal count, with no `halt_req`:
    - If `bp_en` is high, `pc_if`==`bp_addr`, and the skip flag is 0: go to BREAK, set `bp_hit`, issue no pulse.
    - Otherwise: `pipe_en`=1 next cycle and clear the skip flag.
  - `halt_req` → HALTED, divider cleared, no pulse, even at terminal count.
  - `run_req` and `step_req` are ignored in RUN; the divider is not restarted.
- The skip flag guarantees that resuming from a breakpoint executes the breakpointed instruction instead of re-stopping immediately.
- `cycle_cnt` increments on the edge that ends each `pipe_en`-high cycle, wrapping from all-ones to 0.
- Asserting `rst` at any time returns everything to reset values immediately, including mid-pulse: `pipe_en` drops asynchronously.

## Timing
- RUN with no breakpoint: the first `pipe_en` is high `TICK_DIV` cycles after the edge that enters RUN. After that, one pulse every `TICK_DIV` cycles.
- Step: `step_req` sampled at edge N → `pipe_en` high in cycle N+1 (state STEP) → low in N+2 (state HALTED). `cycle_cnt` shows +1 from N+2.
- Halt latency: `state` becomes HALTED one edge after `halt_req` is sampled. No `pipe_en` is issued after that edge.
- Breakpoint: `state`=BREAK and `bp_hit`=1 one edge after the matching terminal count. `pc_if` is sampled only at terminal count; changes at other times have no effect.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `pipe_ctrl_pkg`: state encoding constants HALTED, RUN, STEP, BREAK, and the 2-bit state type. The datapath and display use these to decode `state`.
- One sub-module: `pipe_tick_div`. It is a parameterised `TICK_DIV` counter with synchronous clear and enable, a terminal-count output, and the same `Clk` and `rst`.
- Request pulses must already be synchronised and debounced upstream. This block does not debounce.

## Test plan
All scenarios use `TICK_DIV`=4 and `CNT_W`=8.
- Reset then idle 20 cycles → state 0, `pipe_en` never high, `cycle_cnt` 0.
- Three `step_req` pulses spaced 5 cycles apart → exactly three single-cycle `pipe_en` pulses, each one cycle after its request; `cycle_cnt`=3; state back to 0.
- `run_req`, wait 17 cycles, then `halt_req` → four pulses, at cycles 4, 8, 12, 16 after entry; no pulse after the halt edge; state 0.
- `bp_en`=1, `bp_addr`=0x10, `pc_if` steps 0x0,0x4,… per pulse, then `run_req` → BREAK when `pc_if`=0x10 with `bp_hit`=1. A following `run_req` → one pulse at `pc_if`=0x10 without re-break; `bp_hit` cleared.
- `halt_req` and `step_req` in the same cycle while HALTED → no pulse; state stays 0. Repeat while in RUN exactly at terminal count → no pulse; state 0.
- Preload `cycle_cnt`=255 via 255 steps, then one more step → `cycle_cnt` wraps to 0. Assert `rst` low during a STEP cycle → `pipe_en` and state drop to 0 immediately.
